// File: rtl/lcd_text_writer.sv
// Character FIFO + cursor tracker that turns a byte stream into LCD controller transactions.
// Optional automatic line wrap is enabled by defining LCD_LINE_WRAP_EN.
module lcd_text_writer #(
    parameter int          COLS       = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [6:0]  LINE1_ADDR = 7'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        lcd_busy,
    output logic        lcd_enable,
    output logic [9:0]  lcd_bus,
    output logic        cursor_row,
    output logic [5:0]  cursor_col,
    output logic        idle
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);
    localparam logic [5:0]  COLS_W  = 6'(COLS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, empty, push, pop, take, drop;
    logic            pend_valid;
    logic [1:0]      ack_cnt;
    logic [7:0]      head;
    logic            is_nl, is_ff, printable;
    logic [9:0]      line_cmd, bus_nx;

    assign full       = (count == DEPTH_W);
    assign empty      = (count == '0);
    assign char_ready = !full;
    assign push       = char_valid && !full;

    // A pending wrap command wins over the FIFO head; the head then stays queued.
    assign take       = (state == S_IDLE) && !lcd_busy && (pend_valid || !empty);
    assign pop        = take && !pend_valid;

    assign head       = mem[rd_ptr];
    assign is_nl      = (head == 8'h0A);
    assign is_ff      = (head == 8'h0C);
    assign printable  = !is_nl && !is_ff;
    assign line_cmd   = {3'b001, (cursor_row ? 7'h00 : LINE1_ADDR)};

`ifdef LCD_LINE_WRAP_EN
    assign drop = 1'b0;
`else
    // Without wrap, text past the right edge is consumed and discarded.
    assign drop = pop && printable && (cursor_col == COLS_W);
`endif

    assign lcd_enable = (state == S_ISSUE);
    assign idle       = empty && (state == S_IDLE) && !pend_valid;

    always_comb begin
        bus_nx = {2'b10, head};
        if (pend_valid || is_nl)
            bus_nx = line_cmd;
        else if (is_ff)
            bus_nx = 10'h001;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (take && !drop) state_nx = S_ISSUE;
            S_ISSUE:     state_nx = S_WAIT_ACK;
            S_WAIT_ACK:  if (lcd_busy) state_nx = S_WAIT_DONE;
                         else if (ack_cnt == 2'd3) state_nx = S_ISSUE;
            S_WAIT_DONE: if (!lcd_busy) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= char_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lcd_bus    <= '0;
            cursor_row <= 1'b0;
            cursor_col <= '0;
            pend_valid <= 1'b0;
            ack_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);

            case (state)
                S_IDLE: if (take) begin
                    if (!drop)
                        lcd_bus <= bus_nx;
                    if (pend_valid) begin
                        pend_valid <= 1'b0;
                        cursor_row <= ~cursor_row;
                        cursor_col <= '0;
                    end else if (is_nl) begin
                        cursor_row <= ~cursor_row;
                        cursor_col <= '0;
                    end else if (is_ff) begin
                        cursor_row <= 1'b0;
                        cursor_col <= '0;
                    end else if (printable && !drop) begin
                        cursor_col <= cursor_col + 6'd1;
`ifdef LCD_LINE_WRAP_EN
                        if (cursor_col + 6'd1 == COLS_W)
                            pend_valid <= 1'b1;
`endif
                    end
                end
                S_ISSUE:     ack_cnt <= '0;
                S_WAIT_ACK:  ack_cnt <= ack_cnt + 2'd1;
                S_WAIT_DONE: if (!lcd_busy) lcd_bus <= '0;
                default:     ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_text_writer.sv
// Randomised bench for lcd_text_writer: a byte-level model predicts the transaction stream and cursor.
`timescale 1ns/1ps
module tb_lcd_text_writer;
    localparam int         COLS = 16;
    localparam logic [6:0] L1   = 7'h40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_data;
    logic       char_valid, char_ready;
    logic       lcd_busy, busy_hold, busy_resp;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic       cursor_row;
    logic [5:0] cursor_col;
    logic       idle;

    assign lcd_busy = busy_hold | busy_resp;
    always #5 clk = ~clk;

    lcd_text_writer u_dut (
        .clk(clk), .rst(rst), .char_data(char_data), .char_valid(char_valid),
        .char_ready(char_ready), .lcd_busy(lcd_busy), .lcd_enable(lcd_enable),
        .lcd_bus(lcd_bus), .cursor_row(cursor_row), .cursor_col(cursor_col), .idle(idle)
    );

    int         checks = 0, fails = 0;
    logic [9:0] exp_q[$];
    int         mrow = 0, mcol = 0;
    int         strobes = 0, cyc = 0;
    int         strobe_cyc[$];
    logic [9:0] last_bus = '0;
    bit         new_txn = 1'b1;
    bit         resp_on = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] line_cmd(input int row);
        return {3'b001, (row != 0 ? 7'h00 : L1)};
    endfunction

    // Expected transactions for one accepted byte, with eager wrap at the right edge.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0A) begin
            exp_q.push_back(line_cmd(mrow)); mrow = 1 - mrow; mcol = 0;
        end else if (b == 8'h0C) begin
            exp_q.push_back(10'h001); mrow = 0; mcol = 0;
        end else if (mcol < COLS) begin
            exp_q.push_back({2'b10, b}); mcol++;
`ifdef LCD_LINE_WRAP_EN
            if (mcol == COLS) begin
                exp_q.push_back(line_cmd(mrow)); mrow = 1 - mrow; mcol = 0;
            end
`endif
        end
    endtask

    // Compare process: every strobe against the model, and the resting state whenever idle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            new_txn = 1'b1;
        end else begin
            if (lcd_enable) begin
                strobes++;
                strobe_cyc.push_back(cyc);
                check("rw_zero", 32'(lcd_bus[8]), 32'd0);
                if (new_txn) begin
                    if (exp_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_txn: got %0h expected none", lcd_bus);
                    end else begin
                        check("txn_bus", 32'(lcd_bus), 32'(exp_q.pop_front()));
                    end
                    last_bus = lcd_bus;
                    new_txn  = 1'b0;
                end else begin
                    check("restrobe_bus", 32'(lcd_bus), 32'(last_bus));
                end
            end
            if (lcd_busy) new_txn = 1'b1;
            if (idle) begin
                check("idle_q_empty", 32'(exp_q.size()), 32'd0);
                check("idle_row", 32'(cursor_row), 32'(mrow));
                check("idle_col", 32'(cursor_col), 32'(mcol));
                check("idle_bus", 32'(lcd_bus), 32'd0);
            end
        end
    end

    // Controller stand-in: acknowledges a strobe after 1..3 cycles, stays busy 1..4 cycles.
    initial begin
        busy_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (lcd_enable && resp_on && !rst) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2 busy_resp = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #2 busy_resp = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic push(input logic [7:0] b);
        int w = 0;
        char_data  = b;
        char_valid = 1'b1;
        while (!char_ready && w < 500) begin step(); w++; end
        if (w >= 500) begin
            checks++; fails++;
            $display("FAIL push_timeout: got char_ready=0 expected 1");
            char_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_byte(b);
            #2 char_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        step();
        while (!(idle && !lcd_busy) && w < 3000) begin step(); w++; end
        if (w >= 3000) begin
            checks++; fails++;
            $display("FAIL idle_timeout: got idle=%0d expected 1", idle);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n0, w;
        rst = 1'b1; char_data = '0; char_valid = 1'b0; busy_hold = 1'b0;
        repeat (3) step();
        check("rst_enable", 32'(lcd_enable), 32'd0);
        check("rst_bus",    32'(lcd_bus),    32'd0);
        check("rst_row",    32'(cursor_row), 32'd0);
        check("rst_col",    32'(cursor_col), 32'd0);
        check("rst_ready",  32'(char_ready), 32'd1);
        check("rst_idle",   32'(idle),       32'd1);
        rst = 1'b0;
        step();

        // Single character and first-transaction latency
        push(8'h41);
        check("t1_enable_n", 32'(lcd_enable), 32'd0);
        step();
        check("t1_enable_n1", 32'(lcd_enable), 32'd1);
        check("t1_bus", 32'(lcd_bus), 32'h241);
        wait_idle();
        check("t1_col", 32'(cursor_col), 32'd1);

        // Busy controller: FIFO fills, nothing issued, then drains in order
        busy_hold = 1'b1;
        s0 = strobes;
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        check("t2_full", 32'(char_ready), 32'd0);
        char_data = 8'h99; char_valid = 1'b1;
        repeat (3) step();
        check("t2_still_full", 32'(char_ready), 32'd0);
        char_valid = 1'b0;
        check("t2_no_strobe", 32'(strobes - s0), 32'd0);
        busy_hold = 1'b0;
        wait_idle();
        check("t2_drained", 32'(strobes - s0), 32'd8);

        // Newline then form feed
        push(8'h0A);
        wait_idle();
        check("t3_nl_bus", 32'(last_bus), 32'h0C0);
        check("t3_nl_row", 32'(cursor_row), 32'd1);
        check("t3_nl_col", 32'(cursor_col), 32'd0);
        push(8'h0C);
        wait_idle();
        check("t3_ff_bus", 32'(last_bus), 32'h001);
        check("t3_ff_row", 32'(cursor_row), 32'd0);

        // Seventeen printable bytes across the right edge
        s0 = strobes;
        for (int i = 0; i < 17; i++) push(8'h61 + 8'(i));
        wait_idle();
`ifdef LCD_LINE_WRAP_EN
        check("t4_strobes", 32'(strobes - s0), 32'd18);
        check("t4_row", 32'(cursor_row), 32'd1);
        check("t4_col", 32'(cursor_col), 32'd1);
`else
        check("t4_strobes", 32'(strobes - s0), 32'd16);
        check("t4_row", 32'(cursor_row), 32'd0);
        check("t4_col", 32'(cursor_col), 32'd16);
`endif

        // Controller never acknowledges: re-strobe every 5 cycles
        push(8'h0C);
        wait_idle();
        resp_on = 1'b0;
        n0 = strobe_cyc.size();
        push(8'h5A);
        w = 0;
        while (strobe_cyc.size() < n0 + 3 && w < 100) begin step(); w++; end
        resp_on = 1'b1;
        if (strobe_cyc.size() < n0 + 3) begin
            checks++; fails++;
            $display("FAIL t5_retry: got %0d strobes expected 3", strobe_cyc.size() - n0);
        end else begin
            check("t5_gap1", 32'(strobe_cyc[n0+1] - strobe_cyc[n0]), 32'd5);
            check("t5_gap2", 32'(strobe_cyc[n0+2] - strobe_cyc[n0+1]), 32'd5);
        end
        wait_idle();

        // Reset while waiting for the controller with bytes queued
        push(8'h41);
        step();
        busy_hold = 1'b1;
        push(8'h62); push(8'h63); push(8'h64);
        step();
        rst = 1'b1;
        #1;
        check("t6_enable", 32'(lcd_enable), 32'd0);
        check("t6_bus",    32'(lcd_bus),    32'd0);
        check("t6_idle",   32'(idle),       32'd1);
        check("t6_ready",  32'(char_ready), 32'd1);
        exp_q.delete(); mrow = 0; mcol = 0;
        @(posedge clk); #1;
        repeat (2) step();
        busy_hold = 1'b0;
        rst = 1'b0;
        s0 = strobes;
        repeat (20) step();
        check("t6_quiet", 32'(strobes - s0), 32'd0);
        check("t6_idle_after", 32'(idle), 32'd1);
        push(8'h42);
        wait_idle();
        check("t6_new_txn", 32'(strobes - s0), 32'd1);
        check("t6_col", 32'(cursor_col), 32'd1);

        // Random byte stream with control codes, stalls and gaps
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 19);
            if (r == 0)      b = 8'h0A;
            else if (r == 1) b = 8'h0C;
            else             b = 8'h20 + 8'($urandom_range(0, 94));
            if ($urandom_range(0, 24) == 0) begin
                busy_hold = 1'b1;
                repeat ($urandom_range(1, 12)) step();
                busy_hold = 1'b0;
            end
            push(b);
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 29) == 0) wait_idle();
        end
        wait_idle();
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
